// File: rtl/spm_boot_ctrl.sv
// Boot/load controller: holds RISC_SPM in reset, arbitrates pin loader vs Wishbone onto one memory write port.
// Latency: WB write 1-2 cycles to mem_we/ack, ext strobe ~4 cycles; WB stalls via ack, ext has no backpressure (overrun flag).
module spm_boot_ctrl #(
  parameter int RST_HOLD = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              ext_write,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_data,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [ADDR_W-1:0] wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   write_cnt,
  output logic              overrun,
  output logic              wb_drop
);

  typedef enum logic [1:0] {ST_HOLD, ST_LOAD, ST_RUN} state_t;

  localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD);

  state_t              r_state, w_next_state;
  logic [7:0]          r_hold_cnt;
  logic                r_ew_s1, r_ew_s2, r_ew_s3;
  logic [ADDR_W-1:0]   r_ea_s1, r_ea_s2, r_ext_addr;
  logic [DATA_W-1:0]   r_ed_s1, r_ed_s2, r_ext_data;
  logic                r_ext_pend, r_gnt_ext, r_last_wb;
  logic                r_mem_we, r_ack, r_overrun, r_wb_drop;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [ADDR_W:0]     r_write_cnt;

  logic w_in_load, w_enter_load, w_ext_rise, w_ext_req;
  logic w_wb_act, w_wb_wr, w_wb_rd, w_gnt_ext, w_gnt_wb;

  assign w_in_load    = (r_state == ST_LOAD);
  assign w_enter_load = !w_in_load && (w_next_state == ST_LOAD);
  assign w_ext_rise   = r_ew_s2 && !r_ew_s3;
  // A pending ext write is not eligible while its own mem_we pulse is out.
  assign w_ext_req    = r_ext_pend && !r_gnt_ext;
  assign w_wb_act     = wbs_cyc_i && wbs_stb_i && !r_ack;
  assign w_wb_wr      = w_wb_act && wbs_we_i;
  assign w_wb_rd      = w_wb_act && !wbs_we_i;
  assign w_gnt_ext    = w_in_load && w_ext_req && (!w_wb_wr || r_last_wb);
  assign w_gnt_wb     = w_in_load && w_wb_wr && (!w_ext_req || !r_last_wb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_HOLD;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_HOLD: begin
        if (load_req)                w_next_state = ST_LOAD;
        else if (r_hold_cnt <= 8'd1) w_next_state = ST_RUN;
      end
      ST_LOAD: if (!load_req && !r_ext_pend && !w_wb_wr) w_next_state = ST_HOLD;
      ST_RUN:  if (load_req) w_next_state = ST_LOAD;
      default: w_next_state = ST_HOLD;
    endcase
  end

  always_comb begin
    cpu_rst = (r_state != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= HOLD_INIT;
      r_ew_s1    <= 1'b0;
      r_ew_s2    <= 1'b0;
      r_ew_s3    <= 1'b0;
      r_ea_s1    <= '0;
      r_ea_s2    <= '0;
      r_ed_s1    <= '0;
      r_ed_s2    <= '0;
    end else begin
      if (r_state != ST_HOLD)    r_hold_cnt <= HOLD_INIT;
      else if (r_hold_cnt != 0) r_hold_cnt <= r_hold_cnt - 8'd1;
      r_ew_s1 <= ext_write;
      r_ew_s2 <= r_ew_s1;
      r_ew_s3 <= r_ew_s2;
      r_ea_s1 <= ext_addr;
      r_ea_s2 <= r_ea_s1;
      r_ed_s1 <= ext_data;
      r_ed_s2 <= r_ed_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_pend  <= 1'b0;
      r_ext_addr  <= '0;
      r_ext_data  <= '0;
      r_gnt_ext   <= 1'b0;
      r_last_wb   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ack       <= 1'b0;
      r_write_cnt <= '0;
      r_overrun   <= 1'b0;
      r_wb_drop   <= 1'b0;
    end else begin
      if (r_gnt_ext) r_ext_pend <= 1'b0;
      // An edge arriving while the previous one is still pending is dropped.
      if (w_in_load && w_ext_rise && !r_ext_pend) begin
        r_ext_pend <= 1'b1;
        r_ext_addr <= r_ea_s2;
        r_ext_data <= r_ed_s2;
      end

      r_gnt_ext <= w_gnt_ext;
      r_mem_we  <= w_gnt_ext || w_gnt_wb;
      r_ack     <= w_gnt_wb || w_wb_rd || (w_wb_wr && !w_in_load);

      if (w_gnt_ext) begin
        r_mem_addr  <= r_ext_addr;
        r_mem_wdata <= r_ext_data;
        r_last_wb   <= 1'b0;
      end else if (w_gnt_wb) begin
        r_mem_addr  <= wbs_adr_i;
        r_mem_wdata <= wbs_dat_i;
        r_last_wb   <= 1'b1;
      end

      if (w_enter_load) begin
        r_write_cnt <= '0;
        r_overrun   <= 1'b0;
        r_wb_drop   <= 1'b0;
      end else begin
        if ((w_gnt_ext || w_gnt_wb) && !(&r_write_cnt)) r_write_cnt <= r_write_cnt + 1'b1;
        if (w_in_load && w_ext_rise && r_ext_pend)       r_overrun   <= 1'b1;
        if (w_wb_wr && !w_in_load)                       r_wb_drop   <= 1'b1;
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign write_cnt = r_write_cnt;
  assign overrun   = r_overrun;
  assign wb_drop   = r_wb_drop;

endmodule

// File: doc/spm_boot_ctrl.md
# spm_boot_ctrl

Boot/load controller for the RISC_SPM core. Holds the core in reset while its program memory is written. Shares the single memory write port between two requesters: the external pin loader (ext_write strobe with address/data buses) and a Wishbone write port. Releases the core after a programmable reset-hold interval. Sits between the user-project pins/Wishbone bus and the RISC_SPM memory and reset inputs.

## Interface
- RST_HOLD, 4: cycles cpu_rst stays high after loading ends (1..255)
- ADDR_W, 8: memory address width
- DATA_W, 8: memory data width
- clk  in  1  single clock (wb_clk_i at the wrapper)
- rst_n  in  1  asynchronous, active-low reset
- load_req  in  1  level; high requests LOAD mode (from a logic-analyzer bit)
- ext_write  in  1  asynchronous pin strobe; rising edge = one write
- ext_addr  in  ADDR_W  pin address bus
- ext_data  in  DATA_W  pin data bus
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone classic request
- wbs_adr_i  in  ADDR_W  Wishbone address (word index)
- wbs_dat_i  in  DATA_W  Wishbone write data
- wbs_ack_o  out  1  Wishbone acknowledge, one-cycle pulse
- mem_we  out  1  memory write enable, one-cycle pulse
- mem_addr  out  ADDR_W  memory write address
- mem_wdata  out  DATA_W  memory write data
- cpu_rst  out  1  active-high reset to RISC_SPM
- write_cnt  out  ADDR_W+1  writes committed since entering LOAD, saturating
- overrun  out  1  sticky: ext strobe lost
- wb_drop  out  1  sticky: WB write acked outside LOAD

## Operation
- States: HOLD (reset state), LOAD, RUN.
  - HOLD: cpu_rst=1; hold counter decrements every cycle. load_req=1 → LOAD. Counter reaching 0 → RUN.
  - LOAD: cpu_rst=1; memory writes are granted. When load_req=0, ext_pend=0 and no WB request is pending → HOLD, with counter reloaded to RST_HOLD.
  - RUN: cpu_rst=0. load_req=1 → LOAD on the next edge.
- Entering LOAD clears write_cnt, overrun and wb_drop.
- Ext path:
  - ext_write, ext_addr and ext_data pass through a 2-flop synchronizer.
  - A rising edge on the synchronized strobe sets ext_pend and captures the synchronized addr/data.
  - A new edge while ext_pend=1 sets overrun. The captured value is kept and the new strobe is dropped.
  - Edges seen outside LOAD are ignored. They set no flag.
- WB path:
  - A request is cyc&stb&we with ack low.
  - Reads (we=0) get an immediate ack with no side effect.
  - Outside LOAD, writes are acked next cycle, discarded, and set wb_drop.
- Arbitration, LOAD only:
  - At most one grant per cycle.
  - If both requesters are pending, round-robin on last_grant. last_grant resets to WB, so ext wins the first tie.
- A grant produces:
  - mem_we=1 for one cycle, with mem_addr/mem_wdata from the granted source.
  - A WB grant also pulses wbs_ack_o in the same cycle.
  - write_cnt += 1, saturating at 2^ADDR_W+... i.e. all ones of ADDR_W+1 bits.
- mem_addr/mem_wdata hold their last values when mem_we=0.
- Reset values: cpu_rst=1, mem_we=0, mem_addr=0, mem_wdata=0, wbs_ack_o=0, write_cnt=0, overrun=0, wb_drop=0, ext_pend=0, state=HOLD, hold counter=RST_HOLD, synchronizer flops=0.
- rst_n low mid-LOAD aborts immediately. All pending writes are lost and cpu_rst stays 1.

## Timing
- Ext latency: the strobe rise reaches the synchronizer output 2 edges later. ext_pend is set on edge 3. mem_we is asserted in the cycle after edge 3 if uncontested (≤4 cycles if contested).
- Pin buses must be stable ≥3 clk before and after each ext_write rise. Minimum strobe period is 4 clk with no WB contention.
- WB write: mem_we and wbs_ack_o are asserted the cycle after the request is seen, if uncontested. Worst case is 2 cycles.
- HOLD→RUN: cpu_rst falls exactly RST_HOLD cycles after entering HOLD. Out of reset, cpu_rst falls RST_HOLD cycles after rst_n deasserts with load_req=0.
- Simultaneous LOAD exit and grant: the grant completes and the exit is evaluated on the following cycle.

## Test plan
- Reset release with load_req=0, RST_HOLD=4 → cpu_rst falls 4 cycles after rst_n rises. All other outputs stay at their reset values.
- load_req=1, then 3 ext strobes (addr 0x00/0x01/0x02, data 0xA5/0x5A/0xFF), then load_req=0 → three mem_we pulses with matching addr/data, each ≤4 cycles after its strobe. write_cnt=3, cpu_rst falls 4 cycles after the last write.
- In LOAD, an ext strobe and a WB write to 0x10 with data 0x33 pending in the same cycle → ext granted first, WB granted next cycle with wbs_ack_o. The next tie goes to ext again only after a WB win.
- In LOAD, two ext strobe rises 2 cycles apart → overrun=1, only the first addr/data written, write_cnt=1.
- In RUN, a WB write to 0x20 → ack after 1 cycle, no mem_we, wb_drop=1. Entering LOAD clears wb_drop.
- rst_n pulsed low mid-LOAD with ext_pend=1 → no mem_we, cpu_rst=1, state=HOLD, write_cnt=0.
